// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter that lets NUM_MASTERS Wishbone masters share one slave.
// Grants are registered, and a grant is held for as long as the winner keeps cyc high.
// There is one IDLE cycle between any two grants.
// Optional stall watchdog: define WB_ARB_TIMEOUT_EN to build it in.
module wb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*4-1:0]    m_sel_i,
  input  logic [NUM_MASTERS*32-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*32-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [31:0]                 m_dat_o,

  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [3:0]                  s_sel_o,
  output logic [31:0]                 s_adr_o,
  output logic [31:0]                 s_dat_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [31:0]                 s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,

  output logic [NUM_MASTERS-1:0]      gnt_o
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [NUM_MASTERS-1:0] OneLsb = NUM_MASTERS'(1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IdxW-1:0]        cur_idx_q;
  logic [IdxW-1:0]        last_gnt_q;

  logic                   busy;
  logic                   cur_cyc;
  logic                   win_found;
  logic [IdxW-1:0]        win_idx;
  int unsigned            cand;
  logic                   to_hit;

  assign busy    = (state_q == StBusy);
  assign cur_cyc = m_cyc_i[cur_idx_q];
  assign gnt_o   = gnt_q;
  assign m_dat_o = s_dat_i;

  // Round-robin search: start one past the last granted master and wrap around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = 32'(last_gnt_q) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!win_found && m_cyc_i[IdxW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  // Arbitration FSM; grant and last-grant pointer are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      cur_idx_q  <= '0;
      last_gnt_q <= IdxW'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q   <= StBusy;
            gnt_q     <= OneLsb << win_idx;
            cur_idx_q <= win_idx;
          end
        end
        StBusy: begin
          // No preemption: only the owner dropping cyc releases the bus.
          if (!cur_cyc) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            last_gnt_q <= cur_idx_q;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Slave-side mux and response routing; everything reads zero outside BUSY.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (busy && cur_idx_q == IdxW'(i)) begin
        // A watchdog hit withdraws the cycle from the slave for that one cycle.
        s_cyc_o    = m_cyc_i[i] & ~to_hit;
        s_stb_o    = m_stb_i[i] & ~to_hit;
        s_we_o     = m_we_i[i];
        s_sel_o    = m_sel_i[i*4 +: 4];
        s_adr_o    = m_adr_i[i*32 +: 32];
        s_dat_o    = m_dat_i[i*32 +: 32];
        s_cti_o    = m_cti_i[i*3 +: 3];
        s_bte_o    = m_bte_i[i*2 +: 2];
        m_ack_o[i] = s_ack_i;
        m_err_o[i] = s_err_i | to_hit;
        m_rty_o[i] = s_rty_i;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic        raw_stb;
  logic        stall;
  logic [15:0] to_cnt_q;
  logic [15:0] to_cnt_d;

  // Stall is judged on the master's own strobe so the forced-low s_stb_o can't feed back.
  assign raw_stb = busy & m_stb_i[cur_idx_q];
  assign stall   = raw_stb & ~(s_ack_i | s_err_i | s_rty_i);
  assign to_hit  = stall & (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog next count: count stalled cycles, clear on any response, idle or timeout.
  always_comb begin
    to_cnt_d = '0;
    if (stall && !to_hit) to_cnt_d = to_cnt_q + 16'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule
